// File: rtl/cpu_pkg.sv
// Shared definitions for the instruction-fetch stage: FSM encoding and fetch constants.
package cpu_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_REQ  = 2'd1,
      ST_ERR  = 2'd2
   } fetch_state_t;

   localparam int          PC_INC          = 4;
   localparam logic [31:0] INS_RESET       = 32'h0000_0000;
   localparam int          MEM_TIMEOUT_DEF = 16;

   function automatic logic is_word_aligned(input logic [1:0] addr_lsb);
      return (addr_lsb == 2'b00);
   endfunction

endpackage

// File: rtl/ifetch_unit_if.sv
// Instruction-memory read bus between the fetch unit (master) and instruction memory (slave).
interface ifetch_unit_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
);
   logic              imem_rd;
   logic [ADDR_W-1:0] imem_addr;
   logic [DATA_W-1:0] imem_rdata;
   logic              imem_ack;

   modport master (
      output imem_rd,
      output imem_addr,
      input  imem_rdata,
      input  imem_ack
   );

   modport slave (
      input  imem_rd,
      input  imem_addr,
      output imem_rdata,
      output imem_ack
   );
endinterface

// File: rtl/ifetch_unit_watchdog.sv
// Request watchdog: counts cycles spent waiting on instruction memory and flags expiry.
module fetch_watchdog #(
   parameter int MEM_TIMEOUT = 16
) (
   input  logic clk,
   input  logic srst,
   input  logic clear,
   input  logic enable,
   output logic expired
);
   localparam int CW = $clog2(MEM_TIMEOUT + 1);
   localparam logic [CW-1:0] LAST = CW'(MEM_TIMEOUT - 1);

   logic [CW-1:0] count_reg;

   // expired is raised during the MEM_TIMEOUT-th waiting cycle so the FSM leaves on that edge
   assign expired = enable && (count_reg == LAST);

   always_ff @(posedge clk) begin
      if (srst || clear) begin
         count_reg <= '0;
      end else if (enable && !expired) begin
         count_reg <= count_reg + 1'b1;
      end
   end
endmodule

// File: rtl/ifetch_unit.sv
// Instruction-fetch stage: PC, instruction register, imem read FSM and redirect handling.
// Optional build macro FETCH_COUNT_EN adds a 32-bit completed-fetch counter output.
module ifetch_unit
   import cpu_pkg::*;
#(
   parameter int ADDR_W      = 32,
   parameter int DATA_W      = 32,
   parameter int MEM_TIMEOUT = MEM_TIMEOUT_DEF
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic [ADDR_W-1:0] outside_pc,
   input  logic              fetch_req,
   input  logic              redirect_valid,
   input  logic [ADDR_W-1:0] redirect_pc,
   ifetch_unit_if.master     imem,
   output logic [DATA_W-1:0] ins,
   output logic [ADDR_W-1:0] now_pc,
   output logic [ADDR_W-1:0] pc_plus4,
   output logic              ir_valid,
   output logic              busy,
   output logic              fetch_err
`ifdef FETCH_COUNT_EN
   ,
   output logic [31:0]       fetch_count
`endif
);
   fetch_state_t      state_reg;
   logic [ADDR_W-1:0] pc_reg;
   logic [ADDR_W-1:0] now_pc_reg;
   logic [DATA_W-1:0] ins_reg;
   logic              ir_valid_reg;
   logic              imem_rd_reg;
   logic              busy_reg;
   logic              err_reg;
   logic              pend_valid_reg;
   logic [ADDR_W-1:0] pend_pc_reg;

   logic              bad_redirect;
   logic              fetch_done;
   logic              wd_expired;
   logic [ADDR_W-1:0] reset_pc;
   logic              unused_lsb;

   assign reset_pc     = {outside_pc[ADDR_W-1:2], 2'b00};
   assign unused_lsb   = &{1'b0, outside_pc[1:0]};
   assign bad_redirect = redirect_valid && !is_word_aligned(redirect_pc[1:0]);
   assign fetch_done   = (state_reg == ST_REQ) && imem.imem_ack && !bad_redirect;

   fetch_watchdog #(
      .MEM_TIMEOUT (MEM_TIMEOUT)
   ) u_watchdog (
      .clk     (CLK),
      .srst    (RST),
      .clear   (state_reg != ST_REQ),
      .enable  (state_reg == ST_REQ),
      .expired (wd_expired)
   );

   always_ff @(posedge CLK) begin
      if (RST) begin
         state_reg      <= ST_IDLE;
         pc_reg         <= reset_pc;
         now_pc_reg     <= reset_pc;
         ins_reg        <= DATA_W'(INS_RESET);
         ir_valid_reg   <= 1'b0;
         imem_rd_reg    <= 1'b0;
         busy_reg       <= 1'b0;
         err_reg        <= 1'b0;
         pend_valid_reg <= 1'b0;
         pend_pc_reg    <= '0;
      end else begin
         ir_valid_reg <= 1'b0;
         case (state_reg)
            ST_IDLE: begin
               if (bad_redirect) begin
                  state_reg <= ST_ERR;
                  err_reg   <= 1'b1;
               end else begin
                  if (redirect_valid) pc_reg <= redirect_pc;
                  if (fetch_req) begin
                     state_reg   <= ST_REQ;
                     imem_rd_reg <= 1'b1;
                     busy_reg    <= 1'b1;
                  end
               end
            end
            ST_REQ: begin
               if (bad_redirect || (wd_expired && !imem.imem_ack)) begin
                  state_reg      <= ST_ERR;
                  imem_rd_reg    <= 1'b0;
                  busy_reg       <= 1'b0;
                  err_reg        <= 1'b1;
                  pend_valid_reg <= 1'b0;
               end else if (fetch_done) begin
                  state_reg      <= ST_IDLE;
                  imem_rd_reg    <= 1'b0;
                  busy_reg       <= 1'b0;
                  ins_reg        <= imem.imem_rdata;
                  now_pc_reg     <= pc_reg;
                  ir_valid_reg   <= 1'b1;
                  pend_valid_reg <= 1'b0;
                  // a redirect arriving on the completion edge is the newest one and wins
                  if (redirect_valid)      pc_reg <= redirect_pc;
                  else if (pend_valid_reg) pc_reg <= pend_pc_reg;
                  else                     pc_reg <= pc_reg + ADDR_W'(PC_INC);
               end else if (redirect_valid) begin
                  pend_valid_reg <= 1'b1;
                  pend_pc_reg    <= redirect_pc;
               end
            end
            default: begin
               state_reg   <= ST_ERR;
               imem_rd_reg <= 1'b0;
               busy_reg    <= 1'b0;
               err_reg     <= 1'b1;
            end
         endcase
      end
   end

`ifdef FETCH_COUNT_EN
   logic [31:0] fetch_count_reg;

   always_ff @(posedge CLK) begin
      if (RST) begin
         fetch_count_reg <= '0;
      end else if (fetch_done) begin
         fetch_count_reg <= fetch_count_reg + 32'd1;
      end
   end

   assign fetch_count = fetch_count_reg;
`endif

   assign imem.imem_rd   = imem_rd_reg;
   assign imem.imem_addr = pc_reg;
   assign ins            = ins_reg;
   assign now_pc         = now_pc_reg;
   assign pc_plus4       = now_pc_reg + ADDR_W'(PC_INC);
   assign ir_valid       = ir_valid_reg;
   assign busy           = busy_reg;
   assign fetch_err      = err_reg;
endmodule

// File: tb/tb_ifetch_unit.sv
// Self-checking bench for ifetch_unit: directed fetch sequences against a queue-based fetch model.
module tb_ifetch_unit;
   localparam int AW  = 32;
   localparam int DW  = 32;
   localparam int TMO = 16;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic [AW-1:0] outside_pc = '0;
   logic          fetch_req = 1'b0;
   logic          redirect_valid = 1'b0;
   logic [AW-1:0] redirect_pc = '0;
   logic [DW-1:0] ins;
   logic [AW-1:0] now_pc;
   logic [AW-1:0] pc_plus4;
   logic          ir_valid;
   logic          busy;
   logic          fetch_err;
`ifdef FETCH_COUNT_EN
   logic [31:0]   fetch_count;
`endif

   ifetch_unit_if #(.ADDR_W(AW), .DATA_W(DW)) imem ();

   ifetch_unit #(.ADDR_W(AW), .DATA_W(DW), .MEM_TIMEOUT(TMO)) dut (
      .CLK            (clk),
      .RST            (rst),
      .outside_pc     (outside_pc),
      .fetch_req      (fetch_req),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .imem           (imem),
      .ins            (ins),
      .now_pc         (now_pc),
      .pc_plus4       (pc_plus4),
      .ir_valid       (ir_valid),
      .busy           (busy),
      .fetch_err      (fetch_err)
`ifdef FETCH_COUNT_EN
      ,
      .fetch_count    (fetch_count)
`endif
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc++;

   int          n_checks = 0;
   int          n_fail   = 0;
   logic [31:0] exp_q[$];
   logic [31:0] exp_ins    = '0;
   logic [31:0] exp_now_pc = '0;
   logic [31:0] next_pc    = '0;
   bit          mem_en     = 1'b1;
   int          mem_wait   = 0;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return {a[15:0], ~a[15:0]} ^ 32'h1357_9BDF;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic fail_bound(input string name);
      n_checks++;
      n_fail++;
      $display("FAIL %s: expected event did not occur within its cycle bound (cycle %0d)", name, cyc);
   endtask

   // instruction memory: acks after mem_wait cycles of imem_rd, returns mem_word(addr)
   initial begin : mem_model
      int cnt;
      cnt = 0;
      imem.imem_ack   = 1'b0;
      imem.imem_rdata = 32'hDEAD_BEEF;
      forever begin
         @(negedge clk);
         if (!rst && mem_en && imem.imem_rd) begin
            if (cnt == mem_wait) begin
               imem.imem_ack   = 1'b1;
               imem.imem_rdata = mem_word(imem.imem_addr);
            end else begin
               imem.imem_ack   = 1'b0;
               imem.imem_rdata = 32'hDEAD_BEEF;
            end
            cnt++;
         end else begin
            imem.imem_ack   = 1'b0;
            imem.imem_rdata = 32'hDEAD_BEEF;
            cnt = 0;
         end
      end
   end

   // per-cycle comparison against the fetch model
   initial begin : compare
      int rd_run;
      bit prev_err;
      logic [31:0] a;
      rd_run   = 0;
      prev_err = 1'b0;
      forever begin
         @(negedge clk);
         if (rst) begin
            rd_run   = 0;
            prev_err = 1'b0;
         end else begin
            if (ir_valid) begin
               if (exp_q.size() == 0) begin
                  fail_bound("ir_valid_without_request");
               end else begin
                  a          = exp_q.pop_front();
                  exp_now_pc = a;
                  exp_ins    = mem_word(a);
               end
            end
            chk("ins", ins, exp_ins);
            chk("now_pc", now_pc, exp_now_pc);
            chk("pc_plus4", pc_plus4, exp_now_pc + 32'd4);
            chk("ir_valid_with_rd", {31'd0, ir_valid & imem.imem_rd}, 32'd0);
            chk("busy_tracks_request", {31'd0, busy}, {31'd0, imem.imem_rd});
            if (imem.imem_rd) begin
               if (exp_q.size() == 0) fail_bound("imem_rd_without_request");
               else chk("imem_addr", imem.imem_addr, exp_q[0]);
               rd_run++;
               if (rd_run > TMO) chk("rd_run_bound", rd_run, TMO);
            end else begin
               if (rd_run == TMO && !ir_valid) chk("timeout_sets_err", {31'd0, fetch_err}, 32'd1);
               rd_run = 0;
            end
            if (fetch_err) chk("err_quiet", {29'd0, ir_valid, imem.imem_rd, busy}, 32'd0);
            if (prev_err) chk("err_sticky", {31'd0, fetch_err}, 32'd1);
            prev_err = fetch_err;
         end
      end
   end

   task automatic do_reset(input logic [31:0] vec);
      @(posedge clk); #1;
      rst            = 1'b1;
      outside_pc     = vec;
      fetch_req      = 1'b0;
      redirect_valid = 1'b0;
      exp_q.delete();
      exp_now_pc     = {vec[31:2], 2'b00};
      exp_ins        = 32'd0;
      next_pc        = {vec[31:2], 2'b00};
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      $display("reset vector=0x%08h now_pc=0x%08h", vec, now_pc);
   endtask

   // mode 0: plain fetch; 1: redirect together with fetch_req; 2: redirect one cycle into the fetch
   task automatic do_fetch(input int mode, input logic [31:0] rpc,
                           output int lat, output logic [31:0] addr0);
      int  t0;
      bit  got_rd;
      @(posedge clk); #1;
      if (mode == 1) begin
         redirect_valid = 1'b1;
         redirect_pc    = rpc;
         next_pc        = rpc;
      end
      fetch_req = 1'b1;
      exp_q.push_back(next_pc);
      next_pc = next_pc + 32'd4;
      t0 = cyc;
      @(posedge clk); #1;
      fetch_req      = 1'b0;
      redirect_valid = 1'b0;
      if (mode == 2) begin
         redirect_valid = 1'b1;
         redirect_pc    = rpc;
         next_pc        = rpc;
      end
      lat    = -1;
      addr0  = 32'hFFFF_FFFF;
      got_rd = 1'b0;
      for (int k = 0; k < 40; k++) begin
         @(negedge clk);
         if (imem.imem_rd && !got_rd) begin
            addr0  = imem.imem_addr;
            got_rd = 1'b1;
         end
         if (ir_valid) begin
            lat = cyc - t0;
            break;
         end
         @(posedge clk); #1;
         redirect_valid = 1'b0;
      end
      redirect_valid = 1'b0;
      if (lat < 0) fail_bound("fetch_completion");
      $display("fetch addr=0x%08h latency=%0d ins=0x%08h now_pc=0x%08h", addr0, lat, ins, now_pc);
   endtask

   initial begin : stimulus
      int          lat;
      logic [31:0] a;
      int          nrd;

      // 1: reset vector is word-aligned, everything idle
      do_reset(32'h0040_0003);
      chk("t1_now_pc", now_pc, 32'h0040_0000);
      chk("t1_ins", ins, 32'h0);
      chk("t1_strobes", {28'd0, ir_valid, imem.imem_rd, busy, fetch_err}, 32'd0);

      // 2: zero-wait back-to-back fetches from 0
      do_reset(32'h0);
      mem_wait = 0;
      for (int i = 0; i < 3; i++) begin
         do_fetch(0, 32'h0, lat, a);
         chk("t2_latency", lat, 2);
         chk("t2_addr", a, 32'(i * 4));
      end
      chk("t2_ins_literal", ins, 32'h135F_6428);

      // 3: redirect during a 3-wait fetch at 0x8
      do_reset(32'h0);
      do_fetch(0, 32'h0, lat, a);
      do_fetch(0, 32'h0, lat, a);
      mem_wait = 3;
      do_fetch(2, 32'h100, lat, a);
      chk("t3_addr", a, 32'h8);
      chk("t3_latency", lat, 5);
      chk("t3_now_pc", now_pc, 32'h8);
      chk("t3_ins_literal", ins, 32'h135F_6428);
      mem_wait = 0;
      do_fetch(0, 32'h0, lat, a);
      chk("t3_next_addr", a, 32'h100);

      // 4: PC wrap at the top of the address space
      do_fetch(1, 32'hFFFF_FFFC, lat, a);
      chk("t4_addr", a, 32'hFFFF_FFFC);
      chk("t4_now_pc", now_pc, 32'hFFFF_FFFC);
      chk("t4_pc_plus4", pc_plus4, 32'h0);
      do_fetch(0, 32'h0, lat, a);
      chk("t4_wrap_addr", a, 32'h0);

      // 5: memory never answers -> watchdog error
      mem_en = 1'b0;
      @(posedge clk); #1;
      fetch_req = 1'b1;
      exp_q.push_back(next_pc);
      @(posedge clk); #1;
      fetch_req = 1'b0;
      nrd = 0;
      for (int k = 0; k < 40; k++) begin
         @(negedge clk);
         if (fetch_err) break;
         if (imem.imem_rd) nrd++;
      end
      if (!fetch_err) fail_bound("t5_timeout");
      $display("timeout rd_cycles=%0d fetch_err=%0b", nrd, fetch_err);
      chk("t5_rd_cycles", nrd, TMO);
      chk("t5_err", {31'd0, fetch_err}, 32'd1);
      chk("t5_rd_low", {31'd0, imem.imem_rd}, 32'd0);
      mem_en = 1'b1;
      @(posedge clk); #1 fetch_req = 1'b1;
      @(posedge clk); #1 fetch_req = 1'b0;
      repeat (3) @(negedge clk);
      chk("t5_req_ignored", {30'd0, imem.imem_rd, busy}, 32'd0);
      chk("t5_err_held", {31'd0, fetch_err}, 32'd1);
      do_reset(32'h0);
      chk("t5_rst_clears", {31'd0, fetch_err}, 32'd0);

      // 6: misaligned redirect, then completed-fetch counting
      @(posedge clk); #1;
      redirect_valid = 1'b1;
      redirect_pc    = 32'h102;
      @(posedge clk); #1 redirect_valid = 1'b0;
      @(negedge clk);
      $display("misaligned redirect 0x102 fetch_err=%0b", fetch_err);
      chk("t6_err", {31'd0, fetch_err}, 32'd1);
      chk("t6_now_pc", now_pc, 32'h0);
      do_reset(32'h0);
`ifdef FETCH_COUNT_EN
      chk("t6_count_reset", fetch_count, 32'd0);
`endif
      for (int i = 0; i < 5; i++) begin
         do_fetch(0, 32'h0, lat, a);
         chk("t6_addr", a, 32'(i * 4));
      end
`ifdef FETCH_COUNT_EN
      chk("t6_count", fetch_count, 32'd5);
      do_reset(32'h0);
      chk("t6_count_cleared", fetch_count, 32'd0);
`endif

      repeat (2) @(negedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin : global_bound
      #200000;
      $display("FAIL global_timeout: simulation did not finish, got cycle %0d, required < 20000", cyc);
      $fatal(1, "global timeout");
   end
endmodule
